// File: rtl/display_scan_ctrl_if.sv
// Interface between the display scan controller and its host: scan control,
// the value to display, and the per-digit drive outputs.
interface display_scan_ctrl_if;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  NIBBLE;
  logic [3:0]  AN;
  logic        frame_done;

  modport master (
    output enable, load, value,
    input  NIBBLE, AN, frame_done
  );

  modport slave (
    input  enable, load, value,
    output NIBBLE, AN, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with per-slot blanking and
// tear-free frame-synchronous value updates. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  display_scan_ctrl_if.slave bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

`ifdef LEADING_ZERO_BLANK_EN
  // True when every digit at or above position i is zero.
  function automatic logic upper_zero(input logic [15:0] a, input logic [1:0] i);
    logic [15:0] mask;
    mask = 16'hFFFF << {i, 2'b00};
    return ((a & mask) == 16'h0000);
  endfunction
`endif

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]    idx_r, idx_nxt_s;
  logic [15:0]   act_r, act_nxt_s;
  logic [15:0]   shd_r, shd_nxt_s;
  logic          pend_r, pend_nxt_s;
  logic          wrap_s;
  logic [3:0]    an_r, an_nxt_s;
  logic [3:0]    nibble_r, nibble_nxt_s;
  logic          frame_done_r;

  // Next-state, display-value update and next-output computation.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    act_nxt_s   = act_r;
    shd_nxt_s   = shd_r;
    pend_nxt_s  = pend_r;
    wrap_s      = 1'b0;

    if (!bus.enable) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
      idx_nxt_s   = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = BLANK;
          cnt_nxt_s   = '0;
          idx_nxt_s   = 2'd0;
          if (pend_r) begin
            act_nxt_s  = shd_r;
            pend_nxt_s = 1'b0;
          end else begin
            act_nxt_s  = act_r;
          end
        end
        BLANK: begin
          cnt_nxt_s = cnt_r + CW'(1);
          if (cnt_r == BLANK_LAST) begin
            state_nxt_s = SHOW;
          end else begin
            state_nxt_s = BLANK;
          end
        end
        SHOW: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = BLANK;
            cnt_nxt_s   = '0;
            idx_nxt_s   = idx_r + 2'd1;
            wrap_s      = (idx_r == 2'd3);
          end else begin
            cnt_nxt_s   = cnt_r + CW'(1);
          end
          if (wrap_s && pend_r) begin
            act_nxt_s  = shd_r;
            pend_nxt_s = 1'b0;
          end else begin
            act_nxt_s  = act_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
          idx_nxt_s   = 2'd0;
        end
      endcase
    end

    // A load on the wrap cycle goes straight to the active value.
    if (bus.load) begin
      shd_nxt_s = bus.value;
      if (wrap_s) begin
        act_nxt_s  = bus.value;
        pend_nxt_s = 1'b0;
      end else begin
        pend_nxt_s = 1'b1;
      end
    end else begin
      shd_nxt_s = shd_r;
    end

    an_nxt_s = 4'b1111;
    if (state_nxt_s == SHOW) begin
      an_nxt_s = ~(4'b0001 << idx_nxt_s);
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx_nxt_s != 2'd0) && upper_zero(act_nxt_s, idx_nxt_s)) begin
        an_nxt_s = 4'b1111;
      end else begin
        an_nxt_s = ~(4'b0001 << idx_nxt_s);
      end
`endif
    end else begin
      an_nxt_s = 4'b1111;
    end

    nibble_nxt_s = act_nxt_s[{idx_nxt_s, 2'b00} +: 4];
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      idx_r        <= 2'd0;
      act_r        <= 16'h0000;
      shd_r        <= 16'h0000;
      pend_r       <= 1'b0;
      an_r         <= 4'b1111;
      nibble_r     <= 4'h0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      act_r        <= act_nxt_s;
      shd_r        <= shd_nxt_s;
      pend_r       <= pend_nxt_s;
      an_r         <= an_nxt_s;
      nibble_r     <= nibble_nxt_s;
      frame_done_r <= wrap_s;
    end
  end

  assign bus.AN         = an_r;
  assign bus.NIBBLE     = nibble_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random
// stimulus against a frame-position reference model.
module tb_display_scan_ctrl;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan position counted from the first lit-frame cycle.
  bit          m_running;
  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_shd;
  bit          m_pend;
  bit          m_fd;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic en, input logic ld, input logic [15:0] val, input logic rn);
    bit wrap;
    if (!rn) begin
      m_running = 0; m_pos = 0; m_act = 16'h0; m_shd = 16'h0; m_pend = 0; m_fd = 0;
    end else begin
      wrap = m_running && en && (((m_pos + 1) % FRAME) == 0);
      if (!en) begin
        m_running = 0; m_pos = 0;
      end else if (!m_running) begin
        m_running = 1; m_pos = 0;
        if (m_pend) begin m_act = m_shd; m_pend = 0; end
      end else begin
        m_pos++;
        if (wrap) begin
          if (m_pend) m_act = m_shd;
          m_pend = 0;
        end
      end
      if (ld) begin
        m_shd = val;
        if (wrap) begin m_act = val; m_pend = 0; end
        else m_pend = 1;
      end
      m_fd = wrap;
    end
  endtask

  function automatic int cur_slot();
    return m_running ? ((m_pos / CLK_DIV) % 4) : 0;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0]  a;
    logic [15:0] up;
    int s;
    a = 4'hF;
    s = cur_slot();
    up = m_act >> (4 * s);
    if (m_running && ((m_pos % CLK_DIV) >= BLANK)) begin
      a[s] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (s > 0 && up == 16'h0) a = 4'hF;
`endif
    end
    return a;
  endfunction

  function automatic logic [3:0] exp_nib();
    logic [15:0] t;
    t = m_act >> (4 * cur_slot());
    return t[3:0];
  endfunction

  task automatic cycle(input logic en, input logic ld, input logic [15:0] val, input logic rn);
    rst_n = rn; bus.enable = en; bus.load = ld; bus.value = val;
    @(posedge clk);
    model_step(en, ld, val, rn);
    #1;
    check("an", {12'h0, bus.AN}, {12'h0, exp_an()});
    check("nibble", {12'h0, bus.NIBBLE}, {12'h0, exp_nib()});
    check("frame_done", {15'h0, bus.frame_done}, {15'h0, m_fd});
    check("an_one_low", {15'h0, ($countones(~bus.AN) <= 1)}, 16'h1);
  endtask

  // Advance with enable high until the model sits at frame position tgt.
  task automatic run_to(input int tgt);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_running && (m_pos % FRAME) == tgt) return;
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
    end
    check("run_to_timeout", 16'h0, 16'h1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; bus.enable = 1'b0; bus.load = 1'b0; bus.value = 16'h0;

    // Reset state
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    check("rst_an", {12'h0, bus.AN}, 16'h000F);
    check("rst_nibble", {12'h0, bus.NIBBLE}, 16'h0000);

    // First frame blank/lit pattern, 1234 appears from the second frame
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b1, 16'h1234, 1'b1);
    run_to(31);
    run_to(2);
    check("f2_d0_an", {12'h0, bus.AN}, 16'h000E);
    check("f2_d0_nib", {12'h0, bus.NIBBLE}, 16'h0004);
    run_to(26);
    check("f2_d3_an", {12'h0, bus.AN}, 16'h0007);
    check("f2_d3_nib", {12'h0, bus.NIBBLE}, 16'h0001);

    // Mid-frame load does not tear the current frame
    cycle(1'b1, 1'b1, 16'hABCD, 1'b1);
    run_to(31);
    run_to(12);
    cycle(1'b1, 1'b1, 16'h5678, 1'b1);
    run_to(20);
    check("tear_d2_nib", {12'h0, bus.NIBBLE}, 16'h000B);
    run_to(31);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("wrap_fd", {15'h0, bus.frame_done}, 16'h0001);
    check("wrap_nib", {12'h0, bus.NIBBLE}, 16'h0008);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("fd_one_cycle", {15'h0, bus.frame_done}, 16'h0000);

    // Last of several loads wins; load on the wrap cycle goes direct
    run_to(5);
    cycle(1'b1, 1'b1, 16'h1111, 1'b1);
    cycle(1'b1, 1'b1, 16'h2222, 1'b1);
    run_to(31);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("multi_load_nib", {12'h0, bus.NIBBLE}, 16'h0002);
    run_to(31);
    cycle(1'b1, 1'b1, 16'h3333, 1'b1);
    check("wrap_load_nib", {12'h0, bus.NIBBLE}, 16'h0003);
    run_to(31);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("wrap_load_kept", {12'h0, bus.NIBBLE}, 16'h0003);

    // Enable drop during digit-2 SHOW
    run_to(20);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("dis_an", {12'h0, bus.AN}, 16'h000F);
    check("dis_fd", {15'h0, bus.frame_done}, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    check("reen_d0_an", {12'h0, bus.AN}, 16'h000E);

    // Reset mid-SHOW, load during reset ignored
    run_to(4);
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);
    check("mid_rst_an", {12'h0, bus.AN}, 16'h000F);
    check("mid_rst_nib", {12'h0, bus.NIBBLE}, 16'h0000);
    run_to(31);
    run_to(12);
    check("post_rst_nib", {12'h0, bus.NIBBLE}, 16'h0000);

    // Leading-digit handling, value copied on IDLE->BLANK
    cycle(1'b0, 1'b1, 16'h0050, 1'b1);
    run_to(26);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d3_an", {12'h0, bus.AN}, 16'h000F);
    run_to(18);
    check("lz_d2_an", {12'h0, bus.AN}, 16'h000F);
`else
    check("lz_d3_an", {12'h0, bus.AN}, 16'h0007);
`endif
    run_to(10);
    check("lz_d1_an", {12'h0, bus.AN}, 16'h000D);
    check("lz_d1_nib", {12'h0, bus.NIBBLE}, 16'h0005);
    cycle(1'b0, 1'b1, 16'h0000, 1'b1);
    run_to(3);
    check("zero_d0_an", {12'h0, bus.AN}, 16'h000E);
    run_to(13);
`ifdef LEADING_ZERO_BLANK_EN
    check("zero_d1_an", {12'h0, bus.AN}, 16'h000F);
`else
    check("zero_d1_an", {12'h0, bus.AN}, 16'h000D);
`endif

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0,
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
            16'($urandom),
            ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1000, dead-time cycles at slot start with all anodes off; legal range 1..CLK_DIV-1.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port enable  input  1  scan enable; low means display dark.
REQ-006 The block SHALL have port load  input  1  single-cycle strobe capturing value.
REQ-007 The block SHALL have port value  input  16  four hex digits; [3:0] is digit 0 (rightmost).
REQ-008 The block SHALL have port NIBBLE  output  4  current digit code, driven to the 7-segment decoder input.
REQ-009 The block SHALL have port AN  output  4  anode selects, active-low, at most one bit low.
REQ-010 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-011 The block SHALL implement FSM states IDLE, BLANK and SHOW, with slot counter cnt (0..CLK_DIV-1), digit index idx (0..3), active register act[15:0], shadow register shd[15:0] and flag pend.
REQ-012 In IDLE the block SHALL hold AN=4'b1111 and cnt=0, and SHALL hold idx at 0; when enable=1 it SHALL move to BLANK on the next edge.
REQ-013 In BLANK the block SHALL hold AN=4'b1111 and NIBBLE=act[4*idx+:4]; when cnt reaches BLANK_CYCLES-1 it SHALL move to SHOW.
REQ-014 In SHOW the block SHALL drive AN[idx]=0 and all other AN bits 1; when cnt reaches CLK_DIV-1 it SHALL reset cnt to 0, set idx to (idx+1) mod 4 and move to BLANK.
REQ-015 Slot length SHALL be exactly CLK_DIV cycles: BLANK_CYCLES blank cycles followed by CLK_DIV-BLANK_CYCLES lit cycles.
REQ-016 On a slot end with idx=3 (frame wrap), the block SHALL pulse frame_done high for exactly one cycle, the cycle after the transition edge.
REQ-017 When load=1 outside a frame-wrap cycle, the block SHALL set shd<=value and pend<=1; act SHALL be unchanged, so there is no mid-frame tearing.
REQ-018 At a frame wrap, the block SHALL set act<=shd and pend<=0 if pend=1.
REQ-019 If load=1 in the frame-wrap cycle, the block SHALL set act<=value directly and pend<=0, so load wins over a stale shd.
REQ-020 When multiple loads occur before a wrap, only the last value SHALL be applied.
REQ-021 When enable=1 in IDLE with pend=1, the block SHALL copy shd to act on the IDLE->BLANK edge.
REQ-022 When enable falls in any state, the block SHALL go to IDLE on the next edge with AN=4'b1111, cnt=0 and idx=0; pend and shd SHALL be kept; no frame_done pulse SHALL occur.
REQ-023 Outputs SHALL be registered: NIBBLE and AN change only on clk edges, and AN SHALL never have two bits low in any cycle.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL set state=IDLE, cnt=0, idx=0, act=0, shd=0, pend=0, AN=4'b1111, NIBBLE=4'h0 and frame_done=0.
REQ-025 Reset asserted mid-slot SHALL take effect at the next edge with no completion of the slot or frame.
REQ-026 A load in a reset cycle SHALL be ignored.

Configuration
REQ-027 The block SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-028 With LEADING_ZERO_BLANK_EN defined, during SHOW the block SHALL force AN to 4'b1111 for any digit idx>0 for which act[15:4*idx] is all zero; slot timing SHALL be unchanged, and digit 0 SHALL always be lit.
REQ-029 Without LEADING_ZERO_BLANK_EN, all four digits SHALL be lit in SHOW regardless of value.

Verification (CLK_DIV=8, BLANK_CYCLES=2 unless stated)
REQ-030 The bench SHALL cover: reset, enable=1, load value=16'h1234 -> first full frame AN sequence 1111x2,1110x6,1111x2,1101x6,1111x2,1011x6,1111x2,0111x6; NIBBLE 4,3,2,1 from the second frame on.
REQ-031 The bench SHALL cover: act=16'hABCD, load 16'h5678 in digit-1 SHOW -> remaining digits of the frame show B,A; the next frame shows 8,7,6,5; frame_done high one cycle per 32.
REQ-032 The bench SHALL cover: load 16'h1111 then 16'h2222 before wrap, and separately load 16'h3333 exactly on the wrap cycle -> act=16'h2222 in the first case and 16'h3333 in the second; pend=0 after each.
REQ-033 The bench SHALL cover: enable dropped during digit-2 SHOW -> AN=1111 next cycle, idx=0; re-enable -> restarts BLANK of digit 0; no frame_done pulse.
REQ-034 The bench SHALL cover: rst_n low for 1 cycle mid-SHOW -> all outputs at reset values next cycle, act=0.
REQ-035 The bench SHALL cover, with LEADING_ZERO_BLANK_EN defined and value=16'h0050: digit 3 and digit 2 slots AN=1111, digit 1 lit with 5, digit 0 lit with 0; with value=16'h0000, only digit 0 lit.
REQ-036 The bench SHALL check throughout that AN never has more than one bit low.
